// File: rtl/hash_core_arbiter.sv
// hash_core_arbiter
// Shares a single H_for_s_tree hash core among N requesters with round-robin
// arbitration. The winner's 512-bit message is latched at grant, the core is
// driven through a level start/end handshake, and the 256-bit digest is
// returned with a one-cycle done pulse on the winner's lane.
// Optional feature macro: HASH_ARB_TIMEOUT_EN adds a WAIT_END watchdog that
// aborts an operation after TIMEOUT cycles without core_end.
module hash_core_arbiter #(
    parameter int N       = 4,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*512-1:0] req_msg,
    output logic [N-1:0]     req_grant,
    output logic [N-1:0]     resp_done,
    output logic [255:0]     resp_hash,
    output logic [511:0]     core_msg,
    output logic             core_start,
    input  logic [255:0]     core_hash,
    input  logic             core_end,
    output logic             busy,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_END = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [N-1:0]     grant_onehot;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand_idx;
    logic [511:0]     pick_msg;
    logic [511:0]     msg_arr [N];

    logic             timeout_hit;

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign msg_arr[g] = req_msg[g*512 +: 512];
    end

    assign grant_onehot = N'(1) << grant_idx;
    assign next_ptr     = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Round-robin search: the valid requester at the smallest offset from rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(off);
            if (cand_sum >= (PTR_W + 1)'(N)) begin
                cand_sum = cand_sum - (PTR_W + 1)'(N);
            end
            cand_idx = cand_sum[PTR_W-1:0];
            if ((req_valid & (N'(1) << cand_idx)) != '0) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Select the message slice belonging to the requester about to be granted.
    always_comb begin
        pick_msg = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_msg = msg_arr[i];
            end
        end
    end

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign timeout_hit = (state == WAIT_END) && !core_end &&
                         (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog counter: restarts on entry to WAIT_END and counts cycles spent there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_END) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // One-cycle error pulse when the watchdog abandons an operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; RELEASE holds off re-arbitration until the core drops core_end.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (pick_found) state_next = ISSUE;
            ISSUE:    state_next = WAIT_END;
            WAIT_END: if (core_end || timeout_hit) state_next = RELEASE;
            RELEASE:  if (!core_end) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state so reset clears them at once.
    always_comb begin
        req_grant  = '0;
        core_start = 1'b0;
        busy       = (state != IDLE);
        if (state == ISSUE || state == WAIT_END) begin
            req_grant = grant_onehot;
        end
        if (state == WAIT_END) begin
            core_start = 1'b1;
        end
    end

    // Datapath: latch grant and message, capture the digest and advance the pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            core_msg  <= '0;
            resp_hash <= '0;
            resp_done <= '0;
        end else begin
            resp_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        core_msg  <= pick_msg;
                    end
                end
                WAIT_END: begin
                    if (core_end || timeout_hit) begin
                        resp_done <= grant_onehot;
                        rr_ptr    <= next_ptr;
                        if (core_end) begin
                            resp_hash <= core_hash;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hash_core_arbiter.md
Name: hash_core_arbiter

Overview:
- Shares one H_for_s_tree hash core among N requesters, e.g. seed-tree level expansion, commitment hashing and challenge hashing.
- Grants the core round-robin and latches the granted requester's 512-bit padded message.
- Drives the core's level start/end handshake and returns the 256-bit digest to the winning requester with a one-cycle done pulse.
- Sits between the Picnic signing FSMs and a single hash instance, replacing per-user hash instances.

Parameters:
- N, 4, number of requesters (2..8).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= N.
- TIMEOUT, 255, cycles allowed from core_start to core_end. Used only with HASH_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-requester request level; held high until that requester's resp_done.
- req_msg  input  N*512  flattened messages; requester i occupies bits [512*i+511 : 512*i].
- req_grant  output  N  one-hot; high while requester i owns the core.
- resp_done  output  N  one-hot, one-cycle pulse when resp_hash is valid for requester i.
- resp_hash  output  256  digest of the last completed operation; holds until the next completion.
- core_msg  output  512  registered message to the core.
- core_start  output  1  level start to the core.
- core_hash  input  256  core digest; valid while core_end is high.
- core_end  input  1  core done level; stays high while core_start is high, falls after core_start drops.
- busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Reset values: req_grant=0, resp_done=0, resp_hash=0, core_msg=0, core_start=0, busy=0, err_timeout=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-operation aborts immediately. No resp_done is produced.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
  - Latch that requester's slice of req_msg into core_msg and set req_grant one-hot.
  - Go to ISSUE.
- ISSUE: assert core_start, go to WAIT_END.
- WAIT_END:
  - Hold core_start high.
  - When core_end=1: register core_hash into resp_hash, pulse resp_done[granted], drop core_start, clear req_grant.
  - Set rr_ptr = granted+1, wrapping from N-1 to 0.
  - Go to RELEASE.
- RELEASE: wait for core_end=0, then go to IDLE. No new grant may be issued while core_end is still high.
- Latency: grant at cycle k+1 after req_valid is sampled at cycle k; core_start high at k+2.
  - resp_done fires the cycle after core_end is first sampled high.
  - Minimum turnaround between back-to-back grants is 2 cycles after core_end falls.
- Fairness:
  - A requester that has just been served has the lowest priority at the next arbitration.
  - With all N valid continuously, grants cycle 0,1,2,...,N-1,0,...
- Simultaneous requests are resolved only in IDLE. Requests arriving during WAIT_END wait.
- If req_valid[granted] drops mid-operation, the operation still completes and resp_done still pulses.
- The message is latched at grant. Changes to req_msg after grant have no effect.
- A requester keeping req_valid high after its resp_done is treated as a new request.

Optional Feature:
- Macro: HASH_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width ceil(log2(TIMEOUT+1)) clears on entering WAIT_END and increments each cycle there.
  - If it reaches TIMEOUT with core_end=0: drop core_start, clear req_grant, pulse err_timeout and resp_done[granted], leave resp_hash unchanged.
  - Advance rr_ptr as normal and go to RELEASE.
- When undefined: no counter is built, err_timeout is constant 0, and WAIT_END waits indefinitely.

Test Plan:
- Single request: req_valid=4'b0010, req_msg[1]=M with a core model that has 20-cycle latency -> req_grant=0010 at k+1, core_start at k+2, core_msg=M, resp_done=0010 once, resp_hash equals the model's digest.
- All four requesters held valid for 8 operations -> grant order 0,1,2,3,0,1,2,3, and exactly one resp_done per operation.
- Requester 2 asserts during requester 0's operation while requester 1 is idle -> requester 2 is the next grant; rr_ptr wraps correctly after requester 3.
- Core model holds core_end high for 3 cycles after core_start drops -> no new core_start until core_end=0, and no duplicate resp_done.
- Reset pulsed low during WAIT_END -> all outputs 0 on the same cycle, no resp_done; a fresh request afterwards completes normally starting from requester 0.
- With HASH_ARB_TIMEOUT_EN, TIMEOUT=16 and a core that never ends -> err_timeout and resp_done pulse at cycle 16 of WAIT_END, and resp_hash is unchanged. Without the macro, the block waits and err_timeout stays 0.
